// File: rtl/control_sequencer_if.sv
// Datapath-facing bundle of the control sequencer: fetch handshake, fault flags,
// trap clear, stage enables, trap status, instruction register and retire count.
interface control_sequencer_if #(
  parameter int WORD_WIDTH  = 20,
  parameter int COUNT_WIDTH = 16
);
  logic [WORD_WIDTH-1:0]  instruction;
  logic                   fetch_ready;
  logic                   div_by_zero_flag;
  logic                   mem_violation_flag;
  logic                   mem_corruption_flag;
  logic                   trap_clear;

  logic                   fetch_enable;
  logic                   decode_enable;
  logic                   execute_enable;
  logic                   write_back_enable;
  logic                   trap_mode_flag;
  logic [1:0]             trap_cause;
  logic [WORD_WIDTH-1:0]  current_instruction;
  logic [COUNT_WIDTH-1:0] instr_count;

  // The master side is the datapath/memory environment.
  modport master (
    output instruction, fetch_ready, div_by_zero_flag, mem_violation_flag,
           mem_corruption_flag, trap_clear,
    input  fetch_enable, decode_enable, execute_enable, write_back_enable,
           trap_mode_flag, trap_cause, current_instruction, instr_count
  );

  modport slave (
    input  instruction, fetch_ready, div_by_zero_flag, mem_violation_flag,
           mem_corruption_flag, trap_clear,
    output fetch_enable, decode_enable, execute_enable, write_back_enable,
           trap_mode_flag, trap_cause, current_instruction, instr_count
  );
endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle fetch/decode/execute/write-back sequencer with variable-latency
// execute, write-back-free branch ops and a sticky trap state.
module control_sequencer #(
  parameter int WORD_WIDTH     = 20,
  parameter int OPCODE_WIDTH   = 5,
  parameter int BRANCH_OP_MAX  = 3,
  parameter int LONG_OP_MIN    = 24,
  parameter int LONG_OP_CYCLES = 4,
  parameter int COUNT_WIDTH    = 16
) (
  input logic clk,
  input logic reset,
  control_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_TRAP
  } state_e;

  localparam int EXEC_W = (LONG_OP_CYCLES > 1) ? $clog2(LONG_OP_CYCLES) : 1;
  localparam logic [EXEC_W-1:0]       LONG_LOAD     = EXEC_W'(LONG_OP_CYCLES - 1);
  localparam logic [OPCODE_WIDTH-1:0] BRANCH_MAX_OP = OPCODE_WIDTH'(BRANCH_OP_MAX);
  localparam logic [OPCODE_WIDTH-1:0] LONG_MIN_OP   = OPCODE_WIDTH'(LONG_OP_MIN);

  localparam logic [1:0] CAUSE_NONE   = 2'd0;
  localparam logic [1:0] CAUSE_OPCODE = 2'd1;
  localparam logic [1:0] CAUSE_DIV    = 2'd2;
  localparam logic [1:0] CAUSE_MEM    = 2'd3;

  state_e                  state_q, state_d;
  logic [WORD_WIDTH-1:0]   instr_q, instr_d;
  logic [EXEC_W-1:0]       exec_cnt_q, exec_cnt_d;
  logic [1:0]              cause_q, cause_d;
  logic [COUNT_WIDTH-1:0]  count_q, count_d;

  logic [OPCODE_WIDTH-1:0] op;
  logic                    is_branch;
  logic                    is_long;

  assign op        = instr_q[WORD_WIDTH-1 -: OPCODE_WIDTH];
  assign is_branch = (op != '0) && (op <= BRANCH_MAX_OP);
  assign is_long   = (op >= LONG_MIN_OP);

  // NOTE: every always_comb target gets its hold value first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    exec_cnt_d = exec_cnt_q;
    cause_d    = cause_q;
    count_d    = count_q;

    unique case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        if (bus.fetch_ready) begin
          instr_d = bus.instruction;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        if (op == '0) begin
          cause_d = CAUSE_OPCODE;
          state_d = S_TRAP;
        end else begin
          exec_cnt_d = is_long ? LONG_LOAD : '0;
          state_d    = S_EXECUTE;
        end
      end

      // Faults only matter on the final execute cycle, with divide taking priority.
      S_EXECUTE: begin
        if (exec_cnt_q != '0) begin
          exec_cnt_d = exec_cnt_q - 1'b1;
        end else if (bus.div_by_zero_flag) begin
          cause_d = CAUSE_DIV;
          state_d = S_TRAP;
        end else if (bus.mem_violation_flag || bus.mem_corruption_flag) begin
          cause_d = CAUSE_MEM;
          state_d = S_TRAP;
        end else if (is_branch) begin
          count_d = count_q + 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_WRITEBACK;
        end
      end

      S_WRITEBACK: begin
        count_d = count_q + 1'b1;
        state_d = S_FETCH;
      end

      S_TRAP: begin
        if (bus.trap_clear) begin
          cause_d = CAUSE_NONE;
          state_d = S_FETCH;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      instr_q    <= '0;
      exec_cnt_q <= '0;
      cause_q    <= CAUSE_NONE;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      exec_cnt_q <= exec_cnt_d;
      cause_q    <= cause_d;
      count_q    <= count_d;
    end
  end

  assign bus.fetch_enable        = (state_q == S_FETCH);
  assign bus.decode_enable       = (state_q == S_DECODE);
  assign bus.execute_enable      = (state_q == S_EXECUTE);
  assign bus.write_back_enable   = (state_q == S_WRITEBACK);
  assign bus.trap_mode_flag      = (state_q == S_TRAP);
  assign bus.trap_cause          = cause_q;
  assign bus.current_instruction = instr_q;
  assign bus.instr_count         = count_q;

endmodule
